// File: rtl/dragster_spi_pkg.sv
// rtl/dragster_spi_pkg.sv - shared FSM encoding and frame constants for dragster_spi_master
package dragster_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_HOLD  = 2'd3
  } spi_state_e;

  localparam int   DRAGSTER_FRAME_BITS = 16;
  localparam logic OP_WRITE = 1'b1;
  localparam logic OP_READ  = 1'b0;

endpackage

// File: rtl/spi_clock_divider.sv
// rtl/spi_clock_divider.sv - sclk generator; each bit is CLK_DIV cycles high then CLK_DIV cycles low
module spi_clock_divider #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  output logic sclk,
  output logic rise,
  output logic fall
);

  localparam int CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          half_q, half_d;
  logic          last;

  always_comb begin
    last   = (cnt_q == CW'(CLK_DIV - 1));
    cnt_d  = cnt_q;
    half_d = half_q;
    if (!en) begin
      cnt_d  = '0;
      half_d = 1'b0;
    end else if (last) begin
      cnt_d  = '0;
      half_d = ~half_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q  <= '0;
      half_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      half_q <= half_d;
    end
  end

  // Pulses flag the clk edge at which sclk will change, so the caller acts on that same edge.
  assign sclk = en & ~half_q;
  assign fall = en & ~half_q & last;
  assign rise = en & half_q & last;

endmodule

// File: rtl/dragster_spi_master.sv
// rtl/dragster_spi_master.sv - mode-0 SPI command engine for the Dragster sensor
// DRAGSTER_SPI_READ_EN adds miso capture and the rx_data readback register.
module dragster_spi_master
  import dragster_spi_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int SS_SETUP = 2,
  parameter int SS_HOLD  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        operation,
  input  logic [1:0]  slave_sel,
  input  logic [15:0] tx_word,
  output logic        busy,
  output logic        done,
  output logic [7:0]  rx_data,
  output logic        sclk,
  output logic        mosi,
  input  logic        miso,
  output logic [1:0]  ss_n
);

  localparam int SS_MAX = (SS_SETUP > SS_HOLD) ? SS_SETUP : SS_HOLD;
  localparam int TW     = $clog2(SS_MAX + 1);
  localparam logic [4:0] LAST_BIT = 5'(DRAGSTER_FRAME_BITS - 1);

  spi_state_e    state_q, state_d;
  logic [TW-1:0] tmr_q, tmr_d;
  logic [4:0]    bit_q, bit_d;
  logic [15:0]   sh_q, sh_d;
  logic [1:0]    sel_q, sel_d;
  logic          done_q, done_d;
  logic          div_en, div_rise, div_fall;

`ifdef DRAGSTER_SPI_READ_EN
  logic          op_q, op_d;
  logic [7:0]    rx_sh_q, rx_sh_d;
  logic [7:0]    rx_q, rx_d;
`else
  logic          unused_inputs;
  assign unused_inputs = ^{miso, operation};
`endif

  assign div_en = (state_q == ST_SHIFT);

  spi_clock_divider #(.CLK_DIV(CLK_DIV)) u_div (
    .clk   (clk),
    .reset (reset),
    .en    (div_en),
    .sclk  (sclk),
    .rise  (div_rise),
    .fall  (div_fall)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    sel_d   = sel_q;
    done_d  = 1'b0;
`ifdef DRAGSTER_SPI_READ_EN
    op_d    = op_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
`endif
    case (state_q)
      ST_IDLE: begin
        // done_q blocks acceptance so back-to-back frames always see one idle cycle.
        if (start && !done_q) begin
          state_d = ST_SETUP;
          tmr_d   = '0;
          sel_d   = slave_sel;
`ifdef DRAGSTER_SPI_READ_EN
          op_d    = operation;
          sh_d    = {tx_word[7:0], (operation == OP_WRITE) ? tx_word[15:8] : 8'h00};
`else
          sh_d    = {tx_word[7:0], tx_word[15:8]};
`endif
        end
      end
      ST_SETUP: begin
        if (tmr_q == TW'(SS_SETUP - 1)) begin
          state_d = ST_SHIFT;
          bit_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_SHIFT: begin
        if (div_fall) sh_d = {sh_q[14:0], 1'b0};
        if (div_rise) begin
          if (bit_q == LAST_BIT) begin
            state_d = ST_HOLD;
            tmr_d   = '0;
          end else begin
            bit_d = bit_q + 1'b1;
          end
`ifdef DRAGSTER_SPI_READ_EN
          // The rise closing bit k is the sampling edge of bit k+1; keep bits 8..15.
          if (bit_q >= 5'd7 && bit_q != LAST_BIT) rx_sh_d = {rx_sh_q[6:0], miso};
`endif
        end
      end
      ST_HOLD: begin
        if (tmr_q == TW'(SS_HOLD - 1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
`ifdef DRAGSTER_SPI_READ_EN
          if (op_q == OP_READ) rx_d = rx_sh_q;
`endif
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      sel_q   <= '0;
      done_q  <= 1'b0;
`ifdef DRAGSTER_SPI_READ_EN
      op_q    <= OP_WRITE;
      rx_sh_q <= '0;
      rx_q    <= '0;
`endif
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      sel_q   <= sel_d;
      done_q  <= done_d;
`ifdef DRAGSTER_SPI_READ_EN
      op_q    <= op_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
`endif
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign done = done_q;
  assign ss_n = busy ? ~sel_q : 2'b11;
  assign mosi = div_en & sh_q[15];
`ifdef DRAGSTER_SPI_READ_EN
  assign rx_data = rx_q;
`else
  assign rx_data = 8'h00;
`endif

endmodule

// File: tb/tb_dragster_spi_master.sv
// tb/tb_dragster_spi_master.sv - directed self-checking bench for dragster_spi_master
module tb_dragster_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, operation, miso;
  logic [1:0]  slave_sel;
  logic [15:0] tx_word;
  logic        busy, done, sclk, mosi;
  logic [7:0]  rx_data;
  logic [1:0]  ss_n;

  logic        start2;
  logic        busy2, done2, sclk2, mosi2;
  logic [7:0]  rx2;
  logic [1:0]  ss2;

  int checks = 0;
  int errors = 0;

  dragster_spi_master dut (
    .clk(clk), .reset(reset), .start(start), .operation(operation),
    .slave_sel(slave_sel), .tx_word(tx_word), .busy(busy), .done(done),
    .rx_data(rx_data), .sclk(sclk), .mosi(mosi), .miso(miso), .ss_n(ss_n)
  );

  dragster_spi_master #(.CLK_DIV(2), .SS_SETUP(1), .SS_HOLD(1)) dut_small (
    .clk(clk), .reset(reset), .start(start2), .operation(1'b1),
    .slave_sel(2'b01), .tx_word(16'h1305), .busy(busy2), .done(done2),
    .rx_data(rx2), .sclk(sclk2), .mosi(mosi2), .miso(1'b0), .ss_n(ss2)
  );

  task automatic kick();
    @(negedge clk);
    start = 1'b1;
  endtask

  // Observes one frame of the main DUT; cycle numbers are relative to the accepting cycle.
  task automatic run_frame(input logic [7:0] mbyte, input int pulse_a, input int pulse_b,
                           input int extra, output logic [15:0] mbits, output int done_at,
                           output int ndone, output logic [1:0] ss1, output logic busy1,
                           output int rise1, output int nrise, output logic [7:0] rx_at);
    logic prev;
    int   stop;
    mbits = '0; done_at = 0; ndone = 0; ss1 = 2'b00; busy1 = 1'b0;
    rise1 = 0; nrise = 0; rx_at = 8'h00; prev = 1'b0; miso = 1'b0; stop = 600;
    for (int n = 1; n <= stop; n++) begin
      @(negedge clk);
      if (n == 1) begin
        ss1 = ss_n; busy1 = busy;
        tx_word = 16'hDEAD; slave_sel = 2'b11; operation = ~operation;
      end
      start = (n == pulse_a) || (n == pulse_b);
      if (sclk && !prev) begin
        if (nrise == 0) rise1 = n;
        mbits = {mbits[14:0], mosi};
        nrise++;
      end
      if (!sclk && prev) miso = (nrise >= 8 && nrise <= 15) ? mbyte[15 - nrise] : 1'b0;
      prev = sclk;
      if (done) begin
        ndone++;
        if (done_at == 0) begin
          done_at = n; rx_at = rx_data; stop = n + extra;
        end
      end
    end
    miso = 1'b0;
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; start2 = 1'b0; operation = 1'b1;
    slave_sel = 2'b01; tx_word = 16'h0000; miso = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ss_n !== 2'b11) begin errors++; $display("FAIL reset_ss_n: got %b expected 11", ss_n); end
    checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
    checks++; if (mosi !== 1'b0) begin errors++; $display("FAIL reset_mosi: got %b expected 0", mosi); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_rx_data: got %h expected 00", rx_data); end
    reset = 1'b0;
  endtask

  task automatic test_write();
    logic [15:0] mb; int d, nd, r1, nr; logic [1:0] s1; logic b1; logic [7:0] rx;
    operation = 1'b1; slave_sel = 2'b01; tx_word = 16'h1305;
    kick();
    run_frame(8'h00, 0, 0, 0, mb, d, nd, s1, b1, r1, nr, rx);
    checks++; if (s1 !== 2'b10) begin errors++; $display("FAIL write_ss_n_t1: got %b expected 10", s1); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL write_busy_t1: got %b expected 1", b1); end
    checks++; if (r1 != 3) begin errors++; $display("FAIL write_first_rise: got T+%0d expected T+3", r1); end
    checks++; if (nr != 16) begin errors++; $display("FAIL write_rise_count: got %0d expected 16", nr); end
    checks++; if (mb !== 16'h0513) begin errors++; $display("FAIL write_mosi_bits: got %h expected 0513", mb); end
    checks++; if (d != 133) begin errors++; $display("FAIL write_done_at: got T+%0d expected T+133", d); end
    checks++; if (ss_n !== 2'b11 || busy !== 1'b0) begin errors++; $display("FAIL write_end_state: got ss_n=%b busy=%b expected 11/0", ss_n, busy); end
  endtask

  task automatic test_read();
    logic [15:0] mb, exp_mb; int d, nd, r1, nr; logic [1:0] s1; logic b1; logic [7:0] rx, exp_rx;
`ifdef DRAGSTER_SPI_READ_EN
    exp_mb = 16'h0900; exp_rx = 8'hA5;
`else
    exp_mb = 16'h093C; exp_rx = 8'h00;
`endif
    operation = 1'b0; slave_sel = 2'b10; tx_word = 16'h3C09;
    kick();
    run_frame(8'hA5, 0, 0, 0, mb, d, nd, s1, b1, r1, nr, rx);
    checks++; if (s1 !== 2'b01) begin errors++; $display("FAIL read_ss_n_t1: got %b expected 01", s1); end
    checks++; if (mb !== exp_mb) begin errors++; $display("FAIL read_mosi_bits: got %h expected %h", mb, exp_mb); end
    checks++; if (rx !== exp_rx) begin errors++; $display("FAIL read_rx_data: got %h expected %h", rx, exp_rx); end
    checks++; if (d != 133) begin errors++; $display("FAIL read_done_at: got T+%0d expected T+133", d); end
    operation = 1'b1; slave_sel = 2'b01; tx_word = 16'h0000;
    kick();
    run_frame(8'h00, 0, 0, 0, mb, d, nd, s1, b1, r1, nr, rx);
    checks++; if (rx_data !== exp_rx) begin errors++; $display("FAIL read_rx_held: got %h expected %h", rx_data, exp_rx); end
  endtask

  task automatic test_ignore_start();
    logic [15:0] mb; int d, nd, r1, nr; logic [1:0] s1; logic b1; logic [7:0] rx;
    operation = 1'b1; slave_sel = 2'b01; tx_word = 16'hA55A;
    kick();
    run_frame(8'h00, 10, 50, 3, mb, d, nd, s1, b1, r1, nr, rx);
    checks++; if (nd != 1) begin errors++; $display("FAIL ignore_done_count: got %0d expected 1", nd); end
    checks++; if (d != 133) begin errors++; $display("FAIL ignore_done_at: got T+%0d expected T+133", d); end
    checks++; if (mb !== 16'h5AA5) begin errors++; $display("FAIL ignore_mosi_bits: got %h expected 5aa5", mb); end
  endtask

  task automatic test_back_to_back();
    int dc[3]; int nd, hi_run, min_gap;
    nd = 0; hi_run = 0; min_gap = 1000; dc[0] = 0; dc[1] = 0; dc[2] = 0;
    operation = 1'b1; slave_sel = 2'b01; tx_word = 16'h1305;
    kick();
    for (int n = 1; n <= 450; n++) begin
      @(negedge clk);
      if (ss_n == 2'b11) hi_run++;
      else begin
        if (hi_run > 0 && hi_run < min_gap) min_gap = hi_run;
        hi_run = 0;
      end
      if (done) begin
        dc[nd] = n; nd++;
        if (nd == 3) begin start = 1'b0; break; end
      end
    end
    start = 1'b0;
    checks++; if (nd != 3) begin errors++; $display("FAIL b2b_done_count: got %0d expected 3", nd); end
    checks++; if (dc[0] != 133) begin errors++; $display("FAIL b2b_first_done: got T+%0d expected T+133", dc[0]); end
    checks++; if (dc[1] - dc[0] != 134) begin errors++; $display("FAIL b2b_spacing_1: got %0d expected 134", dc[1] - dc[0]); end
    checks++; if (dc[2] - dc[1] != 134) begin errors++; $display("FAIL b2b_spacing_2: got %0d expected 134", dc[2] - dc[1]); end
    checks++; if (min_gap < 1 || min_gap == 1000) begin errors++; $display("FAIL b2b_ss_gap: got %0d expected >=1", min_gap); end
  endtask

  task automatic test_reset_mid();
    logic [15:0] mb; int d, nd, r1, nr, rises, ndone; logic [1:0] s1; logic b1; logic [7:0] rx; logic prev;
    rises = 0; prev = 1'b0; ndone = 0;
    operation = 1'b1; slave_sel = 2'b10; tx_word = 16'hFFFF;
    kick();
    for (int n = 1; n <= 200; n++) begin
      @(negedge clk);
      start = 1'b0;
      if (sclk && !prev) rises++;
      prev = sclk;
      if (rises == 7) begin reset = 1'b1; break; end
    end
    checks++; if (rises != 7) begin errors++; $display("FAIL midrst_reached_bit7: got %0d rises expected 7", rises); end
    @(negedge clk);
    checks++; if (ss_n !== 2'b11 || sclk !== 1'b0) begin errors++; $display("FAIL midrst_ss_sclk: got ss_n=%b sclk=%b expected 11/0", ss_n, sclk); end
    checks++; if (busy !== 1'b0 || mosi !== 1'b0 || done !== 1'b0 || rx_data !== 8'h00) begin errors++; $display("FAIL midrst_outputs: got busy=%b mosi=%b done=%b rx=%h expected 0/0/0/00", busy, mosi, done, rx_data); end
    reset = 1'b0;
    for (int n = 0; n < 140; n++) begin
      @(negedge clk);
      if (done) ndone++;
    end
    checks++; if (ndone != 0) begin errors++; $display("FAIL midrst_no_done: got %0d expected 0", ndone); end
    slave_sel = 2'b01; tx_word = 16'h1305; operation = 1'b1;
    kick();
    run_frame(8'h00, 0, 0, 0, mb, d, nd, s1, b1, r1, nr, rx);
    checks++; if (d != 133 || mb !== 16'h0513) begin errors++; $display("FAIL midrst_fresh_write: got done=T+%0d bits=%h expected T+133/0513", d, mb); end
  endtask

  task automatic test_small_cfg();
    int r1, r2, d, rises; logic prev;
    r1 = 0; r2 = 0; d = 0; rises = 0; prev = 1'b0;
    @(negedge clk);
    start2 = 1'b1;
    for (int n = 1; n <= 100; n++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (sclk2 && !prev) begin
        rises++;
        if (rises == 1) r1 = n;
        if (rises == 2) r2 = n;
      end
      prev = sclk2;
      if (done2) begin d = n; break; end
    end
    checks++; if (d != 67) begin errors++; $display("FAIL small_done_at: got T+%0d expected T+67", d); end
    checks++; if (r1 != 2) begin errors++; $display("FAIL small_first_rise: got T+%0d expected T+2", r1); end
    checks++; if (r2 - r1 != 4) begin errors++; $display("FAIL small_sclk_period: got %0d expected 4", r2 - r1); end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
    test_small_cfg();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
